cpu_regwrite_arbiter: RTL and testbench

CPU_REGWRITE_ARBITER -- requirements
Module: cpu_regwrite_arbiter

---
 rtl/cpu_regwrite_arbiter_pkg.sv | 25 ++
 rtl/cpu_regwrite_arbiter_rr_pick.sv | 55 +++++
 rtl/cpu_regwrite_arbiter.sv | 87 ++++++++
 tb/tb_cpu_regwrite_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_regwrite_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: requester IDs, widths,
// and the ranking helpers used by the picker and the pointer update.
package cpu_regwrite_arbiter_pkg;
    localparam int NUM_REQ          = 3;
    localparam int IDX_W            = 4;
    localparam int REQ_ID_W         = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_EX  = 2'd0;
    localparam req_id_t REQ_MEM = 2'd1;
    localparam req_id_t REQ_DBG = 2'd2;

    // Position of requester id in the rotation that starts at ptr (0 = first).
    function automatic logic [1:0] rank_of(input req_id_t id, input req_id_t ptr);
        logic [2:0] s;
        s = 3'(id) + 3'd3 - 3'(ptr);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic req_id_t next_ptr(input req_id_t id);
        return (id == REQ_DBG) ? REQ_EX : id + 2'd1;
    endfunction
endpackage

// File: rtl/cpu_regwrite_arbiter_rr_pick.sv
// Ranks requesters (starved first, then rotation from ptr) and returns the top two,
// skipping a second candidate whose destination index collides with the first.
module cpu_rr_pick
    import cpu_regwrite_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]            valid_i,
    input  logic [NUM_REQ-1:0]            prio_i,
    input  req_id_t                       ptr_i,
    input  logic [NUM_REQ-1:0][IDX_W-1:0] index_i,
    output logic                          first_vld_o,
    output req_id_t                       first_id_o,
    output logic                          second_vld_o,
    output req_id_t                       second_id_o
);
    // Lower key wins; keys are unique because rotation ranks are distinct.
    function automatic logic [2:0] pick_min(input logic [NUM_REQ-1:0] m,
                                            input logic [NUM_REQ-1:0][2:0] key);
        logic       found;
        req_id_t    id;
        logic [2:0] best;
        found = 1'b0;
        id    = '0;
        best  = '1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[k] && (!found || key[k] < best)) begin
                found = 1'b1;
                id    = 2'(k);
                best  = key[k];
            end
        end
        return {found, id};
    endfunction

    logic [NUM_REQ-1:0][2:0] key;
    logic [NUM_REQ-1:0]      conflict;
    logic [NUM_REQ-1:0]      cand2;

    always_comb begin
        key = '0;
        for (int k = 0; k < NUM_REQ; k++)
            key[k] = {~prio_i[k], rank_of(2'(k), ptr_i)};
    end

    assign {first_vld_o, first_id_o} = pick_min(valid_i, key);

    // The first pick matches itself, so this mask also removes it from round two.
    always_comb begin
        conflict = '0;
        for (int k = 0; k < NUM_REQ; k++)
            conflict[k] = (index_i[k] == index_i[first_id_o]);
    end

    assign cand2 = valid_i & ~conflict;
    assign {second_vld_o, second_id_o} = pick_min(cand2, key);
endmodule

// File: rtl/cpu_regwrite_arbiter.sv
// Dual-port register-file write arbiter for EX / MEM / DBG requesters with a
// rotating pointer, index-conflict avoidance and starvation promotion.
module cpu_regwrite_arbiter
    import cpu_regwrite_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]    req_index_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_value_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             write_enable0_o,
    output logic [IDX_W-1:0]                 reg_write_index0_o,
    output logic [DATA_W-1:0]                value0_o,
    output logic                             write_enable1_o,
    output logic [IDX_W-1:0]                 reg_write_index1_o,
    output logic [DATA_W-1:0]                value1_o,
    output logic [NUM_REQ-1:0]               starve_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    req_id_t ptr_q;
    logic    first_vld, second_vld;
    req_id_t first_id, second_id;

    cpu_rr_pick u_pick (
        .valid_i      (req_valid_i),
        .prio_i       (starve_o),
        .ptr_i        (ptr_q),
        .index_i      (req_index_i),
        .first_vld_o  (first_vld),
        .first_id_o   (first_id),
        .second_vld_o (second_vld),
        .second_id_o  (second_id)
    );

    // Ready is masked by reset so nothing is handshaken while the block is held.
    always_comb begin
        req_ready_o = '0;
        if (rst_i) begin
            if (first_vld)  req_ready_o[first_id]  = 1'b1;
            if (second_vld) req_ready_o[second_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q              <= REQ_EX;
            write_enable0_o    <= 1'b0;
            reg_write_index0_o <= '0;
            value0_o           <= '0;
            write_enable1_o    <= 1'b0;
            reg_write_index1_o <= '0;
            value1_o           <= '0;
        end else begin
            write_enable0_o <= first_vld;
            write_enable1_o <= second_vld;
            if (first_vld) begin
                reg_write_index0_o <= req_index_i[first_id];
                value0_o           <= req_value_i[first_id];
                ptr_q              <= next_ptr(second_vld ? second_id : first_id);
            end
            if (second_vld) begin
                reg_write_index1_o <= req_index_i[second_id];
                value1_o           <= req_value_i[second_id];
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_starve
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)
                cnt_q <= '0;
            else if (!req_valid_i[k] || req_ready_o[k])
                cnt_q <= '0;
            else if (cnt_q != CNT_W'(STARVE_LIMIT))
                cnt_q <= cnt_q + 1'b1;
        end

        assign starve_o[k] = (cnt_q == CNT_W'(STARVE_LIMIT));
    end
endmodule

// File: tb/tb_cpu_regwrite_arbiter.sv
// Directed bench for cpu_regwrite_arbiter: a vector table plus hand sequences for
// starvation and asynchronous reset.
module tb_cpu_regwrite_arbiter;
    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [2:0]        req_valid_i;
    logic [2:0][3:0]   req_index_i;
    logic [2:0][31:0]  req_value_i;
    logic [2:0]        req_ready_o;
    logic              write_enable0_o, write_enable1_o;
    logic [3:0]        reg_write_index0_o, reg_write_index1_o;
    logic [31:0]       value0_o, value1_o;
    logic [2:0]        starve_o;

    int n_pass  = 0;
    int n_total = 0;

    cpu_regwrite_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_index_i        (req_index_i),
        .req_value_i        (req_value_i),
        .req_ready_o        (req_ready_o),
        .write_enable0_o    (write_enable0_o),
        .reg_write_index0_o (reg_write_index0_o),
        .value0_o           (value0_o),
        .write_enable1_o    (write_enable1_o),
        .reg_write_index1_o (reg_write_index1_o),
        .value1_o           (value1_o),
        .starve_o           (starve_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  vld;
        logic [3:0]  i0, i1, i2;
        logic [31:0] v0, v1, v2;
        logic [2:0]  rdy;
        logic        we0;
        logic [3:0]  x0;
        logic [31:0] d0;
        logic        we1;
        logic [3:0]  x1;
        logic [31:0] d1;
        logic [2:0]  stv;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic [2:0] vld,
                                input logic [3:0] i0, input logic [31:0] v0,
                                input logic [3:0] i1, input logic [31:0] v1,
                                input logic [3:0] i2, input logic [31:0] v2,
                                input logic [2:0] rdy,
                                input logic we0, input logic [3:0] x0, input logic [31:0] d0,
                                input logic we1, input logic [3:0] x1, input logic [31:0] d1);
        vec_t v;
        v.vld = vld; v.i0 = i0; v.v0 = v0; v.i1 = i1; v.v1 = v1; v.i2 = i2; v.v2 = v2;
        v.rdy = rdy; v.we0 = we0; v.x0 = x0; v.d0 = d0; v.we1 = we1; v.x1 = x1; v.d1 = d1;
        v.stv = 3'b000;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] vld,
                         input logic [3:0] i0, input logic [31:0] v0,
                         input logic [3:0] i1, input logic [31:0] v1,
                         input logic [3:0] i2, input logic [31:0] v2);
        req_valid_i    = vld;
        req_index_i[0] = i0; req_value_i[0] = v0;
        req_index_i[1] = i1; req_value_i[1] = v1;
        req_index_i[2] = i2; req_value_i[2] = v2;
    endtask

    initial begin
        // Ranking pointer starts at 0 after reset; entries trace it through.
        vt[0] = mk(3'b011, 4'd2, 32'h11, 4'd5, 32'h22, 4'd0, 32'h0,   // dual issue, P->2
                   3'b011, 1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22);
        vt[1] = mk(3'b100, 4'd9, 32'h0, 4'd9, 32'h0, 4'd0, 32'hDEADBEEF, // DBG alone, P->0
                   3'b100, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0);
        vt[2] = mk(3'b111, 4'd3, 32'h33, 4'd3, 32'h44, 4'd4, 32'h55,  // MEM loses on index 3
                   3'b101, 1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h55);
        vt[3] = mk(3'b010, 4'd0, 32'h0, 4'd3, 32'h44, 4'd0, 32'h0,    // MEM retries alone, P->2
                   3'b010, 1'b1, 4'd3, 32'h44, 1'b0, 4'd0, 32'h0);
        vt[4] = mk(3'b100, 4'd0, 32'h0, 4'd0, 32'h0, 4'd9, 32'h99,    // DBG alone, P->0
                   3'b100, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'h0);
        vt[5] = mk(3'b000, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0,     // idle, enables drop
                   3'b000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        vt[6] = mk(3'b111, 4'd2, 32'hA0, 4'd3, 32'hA1, 4'd4, 32'hA2,  // rotation {0,1}
                   3'b011, 1'b1, 4'd2, 32'hA0, 1'b1, 4'd3, 32'hA1);
        vt[7] = mk(3'b111, 4'd2, 32'hA0, 4'd3, 32'hA1, 4'd4, 32'hA2,  // rotation {2,0}
                   3'b101, 1'b1, 4'd4, 32'hA2, 1'b1, 4'd2, 32'hA0);
        vt[8] = mk(3'b111, 4'd2, 32'hA0, 4'd3, 32'hA1, 4'd4, 32'hA2,  // rotation {1,2}
                   3'b110, 1'b1, 4'd3, 32'hA1, 1'b1, 4'd4, 32'hA2);
        vt[9] = mk(3'b000, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0,
                   3'b000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

        // Reset state, with requests present so ready masking is exercised.
        drive(3'b111, 4'd2, 32'h1, 4'd3, 32'h2, 4'd4, 32'h3);
        #3;
        chk("rst.ready", 32'(req_ready_o), 32'h0);
        chk("rst.we0", 32'(write_enable0_o), 32'h0);
        chk("rst.we1", 32'(write_enable1_o), 32'h0);
        chk("rst.idx0", 32'(reg_write_index0_o), 32'h0);
        chk("rst.val0", value0_o, 32'h0);
        chk("rst.starve", 32'(starve_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].vld, vt[i].i0, vt[i].v0, vt[i].i1, vt[i].v1, vt[i].i2, vt[i].v2);
            #3;
            chk($sformatf("v%0d.ready", i), 32'(req_ready_o), 32'(vt[i].rdy));
            @(posedge clk_i); #1;
            chk($sformatf("v%0d.we0", i), 32'(write_enable0_o), 32'(vt[i].we0));
            if (vt[i].we0) begin
                chk($sformatf("v%0d.idx0", i), 32'(reg_write_index0_o), 32'(vt[i].x0));
                chk($sformatf("v%0d.val0", i), value0_o, vt[i].d0);
            end
            chk($sformatf("v%0d.we1", i), 32'(write_enable1_o), 32'(vt[i].we1));
            if (vt[i].we1) begin
                chk($sformatf("v%0d.idx1", i), 32'(reg_write_index1_o), 32'(vt[i].x1));
                chk($sformatf("v%0d.val1", i), value1_o, vt[i].d1);
            end
            chk($sformatf("v%0d.starve", i), 32'(starve_o), 32'(vt[i].stv));
        end

        // Starvation: EX and MEM collide on index 1 while DBG uses 6. With P=0 the
        // pair {EX,DBG} wins each cycle and returns P to 0, so MEM keeps losing.
        drive(3'b111, 4'd1, 32'hE1, 4'd1, 32'hB1, 4'd6, 32'hD6);
        for (int c = 1; c <= 4; c++) begin
            #3;
            chk($sformatf("stv%0d.ready", c), 32'(req_ready_o), 32'h5);
            @(posedge clk_i); #1;
            chk($sformatf("stv%0d.starve", c), 32'(starve_o), (c == 4) ? 32'h2 : 32'h0);
        end
        #3;
        chk("stv5.ready", 32'(req_ready_o), 32'h6);
        @(posedge clk_i); #1;
        chk("stv5.we0", 32'(write_enable0_o), 32'h1);
        chk("stv5.idx0", 32'(reg_write_index0_o), 32'h1);
        chk("stv5.val0", value0_o, 32'hB1);
        chk("stv5.we1", 32'(write_enable1_o), 32'h1);
        chk("stv5.idx1", 32'(reg_write_index1_o), 32'h6);
        chk("stv5.val1", value1_o, 32'hD6);
        chk("stv5.starve", 32'(starve_o), 32'h0);
        drive(3'b000, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0);
        @(posedge clk_i); #1;

        // Mid-cycle reset: MEM write in flight (P->2), reset pulled with MEM valid.
        drive(3'b010, 4'd0, 32'h0, 4'd5, 32'h5A, 4'd0, 32'h0);
        @(posedge clk_i); #1;
        chk("ar.we0_pre", 32'(write_enable0_o), 32'h1);
        chk("ar.idx0_pre", 32'(reg_write_index0_o), 32'h5);
        #3;
        rst_i = 1'b0;
        #1;
        chk("ar.we0", 32'(write_enable0_o), 32'h0);
        chk("ar.idx0", 32'(reg_write_index0_o), 32'h0);
        chk("ar.val0", value0_o, 32'h0);
        chk("ar.we1", 32'(write_enable1_o), 32'h0);
        chk("ar.ready", 32'(req_ready_o), 32'h0);
        @(posedge clk_i); #1;
        chk("ar.we0_held", 32'(write_enable0_o), 32'h0);
        // After release P must be 0 again: EX outranks DBG on port 0.
        rst_i = 1'b1;
        drive(3'b101, 4'd7, 32'h70, 4'd0, 32'h0, 4'd8, 32'h80);
        #3;
        chk("ar.ready_rel", 32'(req_ready_o), 32'h5);
        chk("ar.we0_rel", 32'(write_enable0_o), 32'h0);
        @(posedge clk_i); #1;
        chk("ar.post_we0", 32'(write_enable0_o), 32'h1);
        chk("ar.post_idx0", 32'(reg_write_index0_o), 32'h7);
        chk("ar.post_val0", value0_o, 32'h70);
        chk("ar.post_we1", 32'(write_enable1_o), 32'h1);
        chk("ar.post_idx1", 32'(reg_write_index1_o), 32'h8);
        chk("ar.post_val1", value1_o, 32'h80);
        drive(3'b000, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0);
        @(posedge clk_i); #1;
        chk("ar.end_we0", 32'(write_enable0_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
